// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave: START/STOP detection, address match, write/read byte sequencing.
// Optional macro I2C_GENERAL_CALL_EN: ACK address byte 0x00 (general call write).
module i2c_slave_byte_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sda_filt_i,
  input  logic       scl_filt_i,
  input  logic [6:0] slave_addr_i,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       start_o,
  output logic       stop_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_ack_o,
  output logic       ovf_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state, state_d;
  logic       scl_q, sda_q;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift, tx_shift_d;
  logic       addr_match, addr_match_d;
  logic       first_flag, first_d;
  logic       master_ack, master_ack_d;
  logic       sda_oe_d, busy_d, start_d, stop_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d, rx_first_d, tx_ack_d, ovf_d;

  logic scl_rise, scl_fall, start_cond, stop_cond, addr_hit;

  assign scl_rise   = !scl_q && scl_filt_i;
  assign scl_fall   = scl_q && !scl_filt_i;
  assign start_cond = scl_q && scl_filt_i && sda_q && !sda_filt_i;
  assign stop_cond  = scl_q && scl_filt_i && !sda_q && sda_filt_i;

  // Evaluated on the 8th address rise: shift_q[6:0] holds the address, sda_filt_i is R/W.
  always_comb begin
`ifdef I2C_GENERAL_CALL_EN
    if (shift_q[6:0] == 7'd0) addr_hit = !sda_filt_i;
    else                      addr_hit = (shift_q[6:0] == slave_addr_i);
`else
    addr_hit = (shift_q[6:0] == slave_addr_i);
`endif
  end

  // rx handshake: rx_valid_o rises with a new byte and holds until sampled with
  // rx_ready_i high at a clock edge; a new byte arrives only while rx_valid_o is low.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift;
    addr_match_d = addr_match;
    first_d      = first_flag;
    master_ack_d = master_ack;
    sda_oe_d     = sda_oe_o;
    busy_d       = busy_o;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    rx_data_d    = rx_data_o;
    rx_valid_d   = rx_valid_o && !rx_ready_i;
    rx_first_d   = rx_first_o;
    tx_ack_d     = 1'b0;
    ovf_d        = 1'b0;

    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      start_d   = 1'b1;
    end else if (stop_cond) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_filt_i};
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) addr_match_d = addr_hit;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (addr_match) begin
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!shift_q[0]) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              first_d   = 1'b1;
              state_d   = WR_DATA;
            end else begin
              tx_shift_d = tx_data_i;
              tx_ack_d   = 1'b1;
              sda_oe_d   = !tx_data_i[7];
              bit_cnt_d  = 4'd1;
              state_d    = RD_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_filt_i};
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (!rx_valid_o) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              rx_first_d = first_flag;
              first_d    = 1'b0;
              sda_oe_d   = 1'b1;
              state_d    = WR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              ovf_d    = 1'b1;
              state_d  = WAIT_STOP;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          // bit_cnt counts bits already placed on SDA
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_d     = 1'b0;
              master_ack_d = 1'b0;
              state_d      = RD_ACK;
            end else begin
              sda_oe_d   = !tx_shift[6];
              tx_shift_d = {tx_shift[6:0], 1'b0};
              bit_cnt_d  = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            master_ack_d = !sda_filt_i;
            if (sda_filt_i) state_d = WAIT_STOP;
          end else if (scl_fall && master_ack) begin
            tx_shift_d = tx_data_i;
            tx_ack_d   = 1'b1;
            sda_oe_d   = !tx_data_i[7];
            bit_cnt_d  = 4'd1;
            state_d    = RD_DATA;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bit_cnt    <= 4'd0;
      shift_q    <= 8'h00;
      tx_shift   <= 8'h00;
      addr_match <= 1'b0;
      first_flag <= 1'b0;
      master_ack <= 1'b0;
      sda_oe_o   <= 1'b0;
      busy_o     <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      rx_first_o <= 1'b0;
      tx_ack_o   <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      state      <= state_d;
      scl_q      <= scl_filt_i;
      sda_q      <= sda_filt_i;
      bit_cnt    <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift   <= tx_shift_d;
      addr_match <= addr_match_d;
      first_flag <= first_d;
      master_ack <= master_ack_d;
      sda_oe_o   <= sda_oe_d;
      busy_o     <= busy_d;
      start_o    <= start_d;
      stop_o     <= stop_d;
      rx_data_o  <= rx_data_d;
      rx_valid_o <= rx_valid_d;
      rx_first_o <= rx_first_d;
      tx_ack_o   <= tx_ack_d;
      ovf_o      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_byte_ctrl;

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic [6:0] slave_addr;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       sda_oe, busy, start_p, stop_p, rx_valid, rx_first, tx_ack, ovf;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_byte_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .sda_filt_i   (sda_line),
    .scl_filt_i   (scl_m),
    .slave_addr_i (slave_addr),
    .sda_oe_o     (sda_oe),
    .busy_o       (busy),
    .start_o      (start_p),
    .stop_o       (stop_p),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .rx_first_o   (rx_first),
    .tx_data_i    (tx_data),
    .tx_ack_o     (tx_ack),
    .ovf_o        (ovf)
  );

  int errors = 0;
  int checks = 0;
  int start_cnt = 0, stop_cnt = 0, tx_ack_cnt = 0, ovf_cnt = 0, oe_cycles = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled mid-cycle after inputs have settled
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (start_p) start_cnt++;
      if (stop_p)  stop_cnt++;
      if (tx_ack)  tx_ack_cnt++;
      if (ovf)     ovf_cnt++;
      if (sda_oe)  oe_cycles++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no byte", {rx_first, rx_data});
        end else begin
          check("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish by 500000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic line);
    sda_m = b;
    tick(4);
    scl_m = 1'b1;
    tick(2);
    line = sda_line;
    tick(2);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    sda_m = 1'b0;
    tick(4);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    sda_m = 1'b1;
    tick(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l);
    clock_bit(1'b1, l);
    ack = !l;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, l);
      b[i] = l;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"},   {31'd0, sda_oe},   32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_start"},    {31'd0, start_p},  32'd0);
    check({tag, "_stop"},     {31'd0, stop_p},   32'd0);
    check({tag, "_rx_data"},  {24'd0, rx_data},  32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_rx_first"}, {31'd0, rx_first}, 32'd0);
    check({tag, "_tx_ack"},   {31'd0, tx_ack},   32'd0);
    check({tag, "_ovf"},      {31'd0, ovf},      32'd0);
  endtask

  typedef struct {
    logic [6:0] sa;
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       ack, l;
    logic [7:0] rd;
    int s0, p0, t0, o0, e0;

    vecs[0] = '{7'h40, 8'h80, 8'h05, 8'hA5, 1'b1};
    vecs[1] = '{7'h40, 8'h82, 8'h11, 8'h22, 1'b0};
    vecs[2] = '{7'h7F, 8'hFE, 8'h00, 8'hFF, 1'b1};
    vecs[3] = '{7'h2A, 8'h54, 8'h3C, 8'h5A, 1'b1};
    vecs[4] = '{7'h2A, 8'h56, 8'h01, 8'h02, 1'b0};
    vecs[5] = '{7'h40, 8'h00, 8'h5A, 8'h12, GC};
    vecs[6] = '{7'h40, 8'h01, 8'h77, 8'h88, 1'b0};
    vecs[7] = '{7'h00, 8'h00, 8'h9C, 8'h63, 1'b1};

    // clock/reset
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    slave_addr = 7'h40;
    rx_ready = 1'b1;
    tx_data = 8'h00;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // START pulse latency and ACK drive latency on the 8th address fall
    sda_m = 1'b0;
    check("start_lat0", {31'd0, start_p}, 32'd0);
    tick(1);
    check("start_lat1", {31'd0, start_p}, 32'd1);
    tick(1);
    check("start_lat2", {31'd0, start_p}, 32'd0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    tick(3);
    scl_m = 1'b0;
    tick(4);
    clock_bit(1'b1, l);
    for (int i = 0; i < 6; i++) clock_bit(1'b0, l);
    sda_m = 1'b0;
    tick(4);
    scl_m = 1'b1;
    tick(4);
    scl_m = 1'b0;
    check("oe_at_fall", {31'd0, sda_oe}, 32'd0);
    tick(1);
    check("oe_fall_plus1", {31'd0, sda_oe}, 32'd1);
    sda_m = 1'b1;
    tick(3);
    scl_m = 1'b1;
    tick(4);
    scl_m = 1'b0;
    tick(4);
    check("oe_after_ack", {31'd0, sda_oe}, 32'd0);
    stop_cond();
    tick(2);
    check("busy_after_stop0", {31'd0, busy}, 32'd0);

    // table of write transactions, rx_ready held high
    for (int i = 0; i < 8; i++) begin
      slave_addr = vecs[i].sa;
      s0 = start_cnt;
      p0 = stop_cnt;
      o0 = oe_cycles;
      if (vecs[i].ack) begin
        exp_q.push_back({1'b1, vecs[i].d0});
        exp_q.push_back({1'b0, vecs[i].d1});
      end
      start_cond();
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      write_byte(vecs[i].addr, ack);
      check($sformatf("v%0d_addr_ack", i), {31'd0, ack}, {31'd0, vecs[i].ack});
      write_byte(vecs[i].d0, ack);
      check($sformatf("v%0d_d0_ack", i), {31'd0, ack}, {31'd0, vecs[i].ack});
      write_byte(vecs[i].d1, ack);
      check($sformatf("v%0d_d1_ack", i), {31'd0, ack}, {31'd0, vecs[i].ack});
      check($sformatf("v%0d_released", i), {31'd0, sda_oe}, 32'd0);
      stop_cond();
      tick(2);
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_start_cnt", i), start_cnt - s0, 32'd1);
      check($sformatf("v%0d_stop_cnt", i), stop_cnt - p0, 32'd1);
      check($sformatf("v%0d_oe_seen", i), {31'd0, (oe_cycles != o0)}, {31'd0, vecs[i].ack});
    end
    check("table_rx_drained", exp_q.size(), 32'd0);

    // overflow: consumer stalls, second byte is refused
    slave_addr = 7'h40;
    rx_ready = 1'b0;
    e0 = ovf_cnt;
    start_cond();
    write_byte(8'h80, ack);
    check("ovf_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h11, ack);
    check("ovf_b1_ack", {31'd0, ack}, 32'd1);
    check("ovf_hold_valid", {31'd0, rx_valid}, 32'd1);
    check("ovf_hold_data", {24'd0, rx_data}, 32'h11);
    check("ovf_hold_first", {31'd0, rx_first}, 32'd1);
    write_byte(8'h22, ack);
    check("ovf_b2_nack", {31'd0, ack}, 32'd0);
    check("ovf_pulse", ovf_cnt - e0, 32'd1);
    write_byte(8'h33, ack);
    check("ovf_wait_stop_nack", {31'd0, ack}, 32'd0);
    check("ovf_pulse_once", ovf_cnt - e0, 32'd1);
    stop_cond();
    tick(2);
    check("ovf_valid_kept", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back({1'b1, 8'h11});
    rx_ready = 1'b1;
    tick(2);
    check("ovf_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("ovf_rx_drained", exp_q.size(), 32'd0);

    // write pointer, repeated START, read two bytes
    s0 = start_cnt;
    t0 = tx_ack_cnt;
    tx_data = 8'h3C;
    exp_q.push_back({1'b1, 8'h06});
    start_cond();
    write_byte(8'h80, ack);
    check("rd_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h06, ack);
    check("rd_ptr_ack", {31'd0, ack}, 32'd1);
    start_cond();
    write_byte(8'h81, ack);
    check("rd_raddr_ack", {31'd0, ack}, 32'd1);
    tx_data = 8'hC3;
    read_byte(rd);
    check("rd_byte1", {24'd0, rd}, 32'h3C);
    clock_bit(1'b0, l);
    read_byte(rd);
    check("rd_byte2", {24'd0, rd}, 32'hC3);
    clock_bit(1'b1, l);
    check("rd_release_after_nack", {31'd0, sda_oe}, 32'd0);
    check("rd_tx_ack_cnt", tx_ack_cnt - t0, 32'd2);
    check("rd_start_cnt", start_cnt - s0, 32'd2);
    stop_cond();
    tick(2);
    check("rd_busy_end", {31'd0, busy}, 32'd0);

    // reset in the middle of a read byte while SDA is pulled low
    tx_data = 8'h00;
    start_cond();
    write_byte(8'h81, ack);
    check("rst_raddr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, l);
    check("rst_oe_before", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    sda_m = 1'b1;
    tick(2);
    exp_q.push_back({1'b1, 8'h44});
    start_cond();
    write_byte(8'h80, ack);
    check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h44, ack);
    check("post_rst_data_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    tick(2);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("final_rx_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
